// File: rtl/frame_writer.sv
// Streams one frame of RGB565 pixels through a 4-entry FIFO into a frame buffer at base_addr+k.
// Define FRAME_WRITER_KEY_SKIP_EN to retire 16'h0000 pixels without a memory write.
module frame_writer #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [15:0]       fifo_mem [4];
  logic [1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [2:0]        occ_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              accept, pop, has_entry, head_zero, last_pix;
  logic [15:0]       head;

  assign head      = fifo_mem[rd_ptr_reg];
  assign has_entry = (occ_reg != 3'd0);
  assign head_zero = (head == 16'h0000);
  assign last_pix  = (count_reg == CNT_W'(TOTAL - 1));
  assign mem_addr  = addr_reg;

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    frame_done = 1'b0;
    pix_ready  = (state_reg == RUN) && (occ_reg != 3'd4);
    accept     = pix_valid && pix_ready;
`ifdef FRAME_WRITER_KEY_SKIP_EN
    // Key-coloured entries still consume their address slot but never reach memory.
    mem_we     = has_entry && !head_zero;
    pop        = has_entry && (head_zero || mem_ack);
`else
    mem_we     = has_entry;
    pop        = has_entry && mem_ack;
`endif
    mem_data   = mem_we ? head : 16'h0000;
    case (state_reg)
      IDLE:  if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (accept && last_pix) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!has_entry || (pop && occ_reg == 3'd1)) state_next = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      occ_reg    <= 3'd0;
      count_reg  <= '0;
      addr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        addr_reg  <= base_addr;
        count_reg <= '0;
      end else begin
        if (pop)    addr_reg  <= addr_reg + ADDR_W'(1);
        if (accept) count_reg <= count_reg + CNT_W'(1);
      end
      if (accept) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({accept, pop})
        2'b10:   occ_reg <= occ_reg + 3'd1;
        2'b01:   occ_reg <= occ_reg - 3'd1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clock) begin
    if (accept) fifo_mem[wr_ptr_reg] <= pix_in;
  end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer at WIDTH=4, HEIGHT=2, ADDR_W=8.
// Expected writes follow FRAME_WRITER_KEY_SKIP_EN when the bench is built with it.
module tb_frame_writer;
  localparam int W = 4, H = 2, AW = 8, NPIX = W * H;

  logic          clock = 1'b0;
  logic          reset, start, pix_valid, mem_ack;
  logic [AW-1:0] base_addr;
  logic [15:0]   pix_in;
  logic          pix_ready, mem_we, busy, frame_done;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;

  frame_writer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_ack(mem_ack), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;
  int ack_hold = 0;
  int d0, q0, sv0;
  logic [15:0] pix [NPIX];

  // Monitor: writes complete where mem_we and mem_ack are both high at the edge.
  logic [AW-1:0] wq_addr [$];
  logic [15:0]   wq_data [$];
  int            done_cnt = 0, stable_viol = 0;
  logic          pend = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [15:0]   pend_data;

  always @(negedge clock) begin
    if (reset) pend = 1'b0;
    else begin
      if (pend && (!mem_we || mem_addr !== pend_addr || mem_data !== pend_data)) stable_viol++;
      if (mem_we && mem_ack) begin
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_data);
      end
      if (frame_done) done_cnt++;
      pend      = mem_we && !mem_ack;
      pend_addr = mem_addr;
      pend_data = mem_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (ack_hold > 0) ack_hold--;
    mem_ack = (ack_hold == 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(pix_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_data"},  32'(mem_data),  32'd0);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input int hold);
    d0  = done_cnt;
    q0  = wq_addr.size();
    sv0 = stable_viol;
    base_addr = base;
    start     = 1'b1;
    ack_hold  = hold;
    mem_ack   = (hold == 0);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input string tag, input int n, output int stall_k);
    int k, guard;
    k = 0; guard = 0; stall_k = -1;
    while (k < n && guard < 200) begin
      pix_valid = 1'b1;
      pix_in    = pix[k];
      if (pix_ready) k++;
      else if (stall_k < 0) stall_k = k;
      tick();
      guard++;
    end
    pix_valid = 1'b0;
    pix_in    = 16'h0000;
    check({tag, "_accepted"}, 32'(k), 32'(n));
  endtask

  task automatic finish_frame(input string tag, input logic [AW-1:0] base);
    int guard, nexp, idx;
    logic [AW-1:0] exp_a;
    guard = 0; nexp = 0;
    while (done_cnt == d0 && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check({tag, "_frame_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_stable"}, 32'(stable_viol - sv0), 32'd0);
    for (int k = 0; k < NPIX; k++) begin
`ifdef FRAME_WRITER_KEY_SKIP_EN
      if (pix[k] == 16'h0000) continue;
`endif
      exp_a = base + AW'(k);
      idx = q0 + nexp;
      if (idx < wq_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, k), 32'(wq_addr[idx]), 32'(exp_a));
        check($sformatf("%s_data%0d", tag, k), 32'(wq_data[idx]), 32'(pix[k]));
      end else begin
        check($sformatf("%s_missing%0d", tag, k), 32'hFFFF_FFFF, 32'(exp_a));
      end
      nexp++;
    end
    check({tag, "_nwrites"}, 32'(wq_addr.size() - q0), 32'(nexp));
    $display("frame %s base=%02h writes=%0d done_pulses=%0d", tag, base,
             wq_addr.size() - q0, done_cnt - d0);
  endtask

  task automatic load_default_pixels();
    for (int k = 0; k < NPIX; k++) pix[k] = 16'h1111 * 16'(k + 1);
  endtask

  initial begin
    int stall;
    reset = 1'b1; start = 1'b0; pix_valid = 1'b0; mem_ack = 1'b1;
    base_addr = '0; pix_in = 16'h0000;
    load_default_pixels();
    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Back-to-back pixels, memory always ready.
    start_frame(8'h10, 0);
    feed("t1", NPIX, stall);
    check("t1_nostall", 32'(stall), 32'hFFFF_FFFF);
    finish_frame("t1", 8'h10);

    // Memory stalls for 10 cycles: FIFO fills after 4 pixels.
    start_frame(8'h20, 10);
    feed("t2", NPIX, stall);
    check("t2_stall_at", 32'(stall), 32'd4);
    finish_frame("t2", 8'h20);

    // Address wraps modulo 256.
    start_frame(8'hFE, 0);
    feed("t3", NPIX, stall);
    finish_frame("t3", 8'hFE);

    // Key-coloured pixel at position 3.
    pix[3] = 16'h0000;
    start_frame(8'h30, 0);
    feed("t4", NPIX, stall);
    finish_frame("t4", 8'h30);
    load_default_pixels();

    // Reset after 5 accepted pixels aborts silently.
    start_frame(8'h50, 0);
    feed("t5", 5, stall);
    reset = 1'b1;
    tick();
    check_idle_outputs("t5_abort");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    $display("frame t5 aborted after 5 pixels, done_pulses=%0d", done_cnt - d0);

    // A fresh frame after the abort completes normally.
    start_frame(8'h40, 0);
    feed("t6", NPIX, stall);
    finish_frame("t6", 8'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-buffer word-address width.
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin writing a frame.
REQ-007 SHALL have port base_addr  input  ADDR_W  frame base address, sampled on accepted start.
REQ-008 SHALL have port pix_in  input  16  filtered RGB565 pixel from the chroma_key/brighten/contrast chain.
REQ-009 SHALL have port pix_valid  input  1  pix_in holds a valid pixel.
REQ-010 SHALL have port pix_ready  output  1  block accepts pix_in this cycle.
REQ-011 SHALL have port mem_addr  output  ADDR_W  write address.
REQ-012 SHALL have port mem_data  output  16  write data.
REQ-013 SHALL have port mem_we  output  1  write request, held until acknowledged.
REQ-014 SHALL have port mem_ack  input  1  memory accepted the current write.
REQ-015 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN SHALL occur on start=1; base_addr latched, pixel count and write address cleared; start in any other state SHALL be ignored.
REQ-019 Pixel SHALL be accepted exactly when pix_valid=1 and pix_ready=1.
REQ-020 pix_ready SHALL be 1 only in RUN with the 4-entry internal FIFO not full; pix_ready SHALL NOT depend combinationally on pix_valid.
REQ-021 Accepted pixels SHALL enter the FIFO in order; a pixel accepted in cycle N SHALL appear on mem_data with mem_we=1 no earlier than cycle N+1.
REQ-022 mem_we, mem_addr, mem_data SHALL stay stable while mem_we=1 and mem_ack=0; a write completes on the cycle mem_we=1 and mem_ack=1, and the next FIFO entry (if any) SHALL be presented the following cycle.
REQ-023 mem_addr SHALL be base_addr + k for the k-th pixel of the frame (k=0..WIDTH*HEIGHT-1), computed by ADDR_W-bit incrementing with modulo-2^ADDR_W wrap; no multiplier.
REQ-024 Simultaneous accept and write-completion with FIFO full SHALL be allowed only if pix_ready was already 1; occupancy SHALL never exceed 4 nor underflow.
REQ-025 After the WIDTH*HEIGHT-th pixel is accepted, state SHALL go RUN->DRAIN and pix_ready SHALL be 0 from the next cycle.
REQ-026 DRAIN->DONE SHALL occur the cycle after the final write completes; DONE SHALL assert frame_done=1 for exactly one cycle and return to IDLE.
REQ-027 pix_valid=1 outside RUN SHALL have no effect.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, FIFO emptied, counters zeroed, pix_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, frame_done=0.
REQ-029 Reset mid-frame SHALL abort immediately, discarding pending pixels, with no frame_done pulse.

Configuration
REQ-030 Macro FRAME_WRITER_KEY_SKIP_EN SHALL control key skipping.
REQ-031 With FRAME_WRITER_KEY_SKIP_EN defined, FIFO entries equal to 16'h0000 SHALL be retired without asserting mem_we (one cycle, no ack needed) while still consuming their address slot k.
REQ-032 Without FRAME_WRITER_KEY_SKIP_EN, every pixel including 16'h0000 SHALL be written.

Verification (WIDTH=4, HEIGHT=2, ADDR_W=8)
REQ-033 base_addr=8'h10, start, 8 pixels 16'h1111..16'h8888 back-to-back, mem_ack always 1 -> writes addr 10..17 in order, one frame_done pulse, busy low after.
REQ-034 mem_ack held 0 for 10 cycles -> pix_ready drops after 4 accepted pixels, mem_we/addr/data stable, no loss or duplication once ack resumes.
REQ-035 base_addr=8'hFE -> addresses FE,FF,00..05.
REQ-036 pixel 3 = 16'h0000 -> with macro, no write at base+3, later addresses unchanged; without macro, write of 0000 at base+3.
REQ-037 reset asserted after 5 accepted pixels -> all outputs at reset values next cycle, no frame_done; new start writes a full frame correctly.
